// File: rtl/mac_cfg_pkg.sv
// Shared definitions for the MAC configuration-port arbiter: FSM encoding,
// register word offsets used by the configuration sequencer, timeout read data.
package mac_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [7:0] {
        REG_REV              = 8'h00,
        REG_SCRATCH          = 8'h01,
        REG_COMMAND_CONFIG   = 8'h02,
        REG_MAC_0            = 8'h03,
        REG_MAC_1            = 8'h04,
        REG_FRM_LENGTH       = 8'h05,
        REG_PAUSE_QUANT      = 8'h06,
        REG_TX_SECTION_EMPTY = 8'h09,
        REG_TX_SECTION_FULL  = 8'h0A,
        REG_TX_ALMOST_EMPTY  = 8'h0D,
        REG_TX_ALMOST_FULL   = 8'h0E,
        REG_TX_IPG_LENGTH    = 8'h17
    } mac_reg_e;

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mac_cfg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 3,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   grant_o,
    output logic            any_o
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                grant_o = PW'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mac_cfg_arbiter.sv
// Round-robin arbiter sharing one waitrequest-stalled MAC register port among
// NREQ requesters, one transaction at a time, with a stall watchdog.
module mac_cfg_arbiter
    import mac_cfg_pkg::*;
#(
    parameter int          NREQ        = 3,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = DEF_ERR_RDATA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*8-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic [7:0]           address,
    output logic                 read,
    output logic                 write,
    output logic [31:0]          writedata,
    input  logic [31:0]          readdata,
    input  logic                 waitrequest
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   pick;
    logic            any_req;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            read_q  <= read_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        read_d  = read_q;
        write_d = write_q;
        ack_d   = '0;
        err_d   = err_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = pick;
                    addr_d  = req_addr[int'(pick) * 8 +: 8];
                    wdata_d = req_wdata[int'(pick) * 32 +: 32];
                    write_d = req_wr[pick];
                    read_d  = !req_wr[pick];
                    timer_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A completing access takes precedence over an expiring watchdog.
                if (!waitrequest) begin
                    if (read_q) begin
                        rdata_d = readdata;
                    end
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = 1'b0;
                    state_d      = ST_DONE;
                end else if (timer_q == T_LAST) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    rdata_d      = ERR_RDATA;
                    ack_d[gnt_q] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign address   = addr_q;
    assign read      = read_q;
    assign write     = write_q;
    assign writedata = wdata_q;

endmodule
